// File: rtl/branch_resolve_pred.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pred
// Description : EX-stage branch resolution plus fetch-stage direction
//               predictor. Resolves conditional branches and jumps from the
//               forwarded operands, flags mispredicts against the prediction
//               carried down the pipe, trains a bimodal table of 2-bit
//               saturating counters, and keeps saturating statistics.
// Ports       : i_clk, i_rst          clock, async active-high reset
//               i_if_pc               fetch PC for lookup
//               o_if_pred_taken       predicted direction (combinational)
//               i_ex_valid/i_ex_stall EX valid / EX hold
//               i_ex_pc, i_ex_instr   EX PC and instruction word
//               i_rs1_data/i_rs2_data forwarded operands
//               i_ex_pred_taken       prediction travelling with EX instr
//               o_pc_sel              resolved taken
//               o_mispredict          resolved != predicted (flush request)
//               o_branch_cnt          resolved control-transfer count
//               o_mispred_cnt         mispredict count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_pred #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PRED_MODE   = 1,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_if_pc,
    output logic             o_if_pred_taken,
    input  logic             i_ex_valid,
    input  logic             i_ex_stall,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [31:0]      i_ex_instr,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic             i_ex_pred_taken,
    output logic             o_pc_sel,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int         c_IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_is_control;

    assign w_opcode     = i_ex_instr[6:0];
    assign w_funct3     = i_ex_instr[14:12];
    assign w_is_branch  = (w_opcode == c_OP_BRANCH);
    assign w_is_jump    = (w_opcode == c_OP_JAL) || (w_opcode == c_OP_JALR);
    assign w_is_control = w_is_branch || w_is_jump;

    // ------------------------------------------------------------------------
    // Compare: single subtractor, extra MSB captures the unsigned borrow.
    // ------------------------------------------------------------------------
    logic [XLEN:0] w_diff;
    logic          w_eq;
    logic          w_ovf;
    logic          w_lt_s;
    logic          w_lt_u;

    assign w_diff = {1'b0, i_rs1_data} - {1'b0, i_rs2_data};
    assign w_eq   = (w_diff[XLEN-1:0] == '0);
    assign w_ovf  = (i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]) &
                    (i_rs1_data[XLEN-1] ^ w_diff[XLEN-1]);
    assign w_lt_s = w_diff[XLEN-1] ^ w_ovf;
    assign w_lt_u = w_diff[XLEN];

    // ------------------------------------------------------------------------
    // Resolve
    // ------------------------------------------------------------------------
    logic w_br_taken;
    logic w_taken;

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = w_eq;
            3'b001:  w_br_taken = ~w_eq;
            3'b100:  w_br_taken = w_lt_s;
            3'b101:  w_br_taken = ~w_lt_s;
            3'b110:  w_br_taken = w_lt_u;
            3'b111:  w_br_taken = ~w_lt_u;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_taken      = w_is_jump | (w_is_branch & w_br_taken);
    assign o_pc_sel     = i_ex_valid & w_taken;
    assign o_mispredict = i_ex_valid & w_is_control & (o_pc_sel != i_ex_pred_taken);

    logic w_upd_en;
    assign w_upd_en = i_ex_valid & ~i_ex_stall;

    // ------------------------------------------------------------------------
    // Direction table
    // ------------------------------------------------------------------------
    generate
        if (PRED_MODE == 1) begin : g_bimodal
            logic [c_IDX_W-1:0] w_if_idx;
            logic [c_IDX_W-1:0] w_ex_idx;
            logic [1:0]         w_ctr [BHT_ENTRIES];
            logic               w_bht_we;

            assign w_if_idx = i_if_pc[c_IDX_W+1:2];
            assign w_ex_idx = i_ex_pc[c_IDX_W+1:2];
            assign w_bht_we = w_upd_en & w_is_branch;

            // Lookup reads the registered value: a same-cycle update to the
            // same entry becomes visible only after the edge.
            assign o_if_pred_taken = w_ctr[w_if_idx][1];

            for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
                logic [1:0] r_ctr;

                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        r_ctr <= 2'b01;
                    end else if (w_bht_we && (w_ex_idx == c_IDX_W'(gi))) begin
                        if (w_br_taken && (r_ctr != 2'b11)) begin
                            r_ctr <= r_ctr + 2'b01;
                        end else if (!w_br_taken && (r_ctr != 2'b00)) begin
                            r_ctr <= r_ctr - 2'b01;
                        end
                    end
                end

                assign w_ctr[gi] = r_ctr;
            end
        end else begin : g_static
            assign o_if_pred_taken = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Statistics (saturating)
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd_en && w_is_control) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (o_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

    // Instruction fields and PC bits outside the decode/index ranges.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_ex_instr[31:15], i_ex_instr[11:7], i_if_pc, i_ex_pc};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_pred.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_pred
// Description : Directed self-checking bench for branch_resolve_pred. A
//               default build and a static-predictor / 4-bit-counter build
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_pred;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [31:0] r_if_pc;
    logic        r_ex_valid;
    logic        r_ex_stall;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_instr;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_ex_pred;

    logic        w_pred;
    logic        w_pc_sel;
    logic        w_mispred;
    logic [31:0] w_bcnt;
    logic [31:0] w_mcnt;

    logic        w_alt_pred;
    logic        w_alt_pc_sel;
    logic        w_alt_mispred;
    logic [3:0]  w_alt_bcnt;
    logic [3:0]  w_alt_mcnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 r_clk = ~r_clk;

    branch_resolve_pred u_dut (
        .i_clk           (r_clk),
        .i_rst           (r_rst),
        .i_if_pc         (r_if_pc),
        .o_if_pred_taken (w_pred),
        .i_ex_valid      (r_ex_valid),
        .i_ex_stall      (r_ex_stall),
        .i_ex_pc         (r_ex_pc),
        .i_ex_instr      (r_ex_instr),
        .i_rs1_data      (r_rs1),
        .i_rs2_data      (r_rs2),
        .i_ex_pred_taken (r_ex_pred),
        .o_pc_sel        (w_pc_sel),
        .o_mispredict    (w_mispred),
        .o_branch_cnt    (w_bcnt),
        .o_mispred_cnt   (w_mcnt)
    );

    branch_resolve_pred #(
        .PRED_MODE (0),
        .CNT_W     (4)
    ) u_alt (
        .i_clk           (r_clk),
        .i_rst           (r_rst),
        .i_if_pc         (r_if_pc),
        .o_if_pred_taken (w_alt_pred),
        .i_ex_valid      (r_ex_valid),
        .i_ex_stall      (r_ex_stall),
        .i_ex_pc         (r_ex_pc),
        .i_ex_instr      (r_ex_instr),
        .i_rs1_data      (r_rs1),
        .i_rs2_data      (r_rs2),
        .i_ex_pred_taken (r_ex_pred),
        .o_pc_sel        (w_alt_pc_sel),
        .o_mispredict    (w_alt_mispred),
        .o_branch_cnt    (w_alt_bcnt),
        .o_mispred_cnt   (w_alt_mcnt)
    );

    localparam logic [2:0] c_F_EQ  = 3'b000;
    localparam logic [2:0] c_F_NE  = 3'b001;
    localparam logic [2:0] c_F_010 = 3'b010;
    localparam logic [2:0] c_F_LT  = 3'b100;
    localparam logic [2:0] c_F_GE  = 3'b101;
    localparam logic [2:0] c_F_LTU = 3'b110;
    localparam logic [2:0] c_F_GEU = 3'b111;

    function automatic logic [31:0] mk_br(input logic [2:0] f3);
        return {17'd0, f3, 5'd0, 7'b1100011};
    endfunction

    localparam logic [31:0] c_JAL  = 32'h0000_00EF;  // jal x1
    localparam logic [31:0] c_JALR = 32'h0000_80E7;  // jalr x1, 0(x1)
    localparam logic [31:0] c_ADD  = 32'h0020_80B3;  // add x1, x1, x2

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic s, input logic [31:0] pc,
                          input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic p);
        r_ex_valid = v;
        r_ex_stall = s;
        r_ex_pc    = pc;
        r_ex_instr = ins;
        r_rs1      = a;
        r_rs2      = b;
        r_ex_pred  = p;
    endtask

    initial begin
        r_rst   = 1'b1;
        r_if_pc = 32'h100;
        set_ex(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // ---------------- reset state (asynchronous, before any edge) -------
        #2;
        chk("rst_bcnt", w_bcnt, 0);
        chk("rst_mcnt", w_mcnt, 0);
        for (int i = 0; i < 4; i++) begin
            r_if_pc = 32'h100 + 32'(i * 4);
            #1;
            chk($sformatf("rst_pred_%0d", i), w_pred, 0);
        end
        tick();
        tick();
        r_rst = 1'b0;

        // ---------------- BEQ taken, mispredicted ---------------------------
        r_if_pc = 32'h100;
        set_ex(1'b1, 1'b0, 32'h100, mk_br(c_F_EQ), 32'd5, 32'd5, 1'b0);
        #1;
        chk("beq_pc_sel", w_pc_sel, 1);
        chk("beq_mispred", w_mispred, 1);
        chk("beq_pred_preupdate", w_pred, 0);
        tick();
        r_ex_valid = 1'b0;
        #1;
        chk("beq_bcnt", w_bcnt, 1);
        chk("beq_mcnt", w_mcnt, 1);
        chk("beq_pred_after", w_pred, 1);
        chk("invalid_pc_sel", w_pc_sel, 0);
        chk("invalid_mispred", w_mispred, 0);

        // ---------------- compare cases, held by stall ----------------------
        set_ex(1'b1, 1'b1, 32'h600, mk_br(c_F_LT), 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1; chk("blt_signed", w_pc_sel, 1);
        r_ex_instr = mk_br(c_F_LTU);
        #1; chk("bltu", w_pc_sel, 0);
        r_ex_instr = mk_br(c_F_GEU);
        #1; chk("bgeu", w_pc_sel, 1);
        set_ex(1'b1, 1'b1, 32'h600, mk_br(c_F_GE), 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        #1; chk("bge_signed", w_pc_sel, 0);
        r_ex_instr = mk_br(c_F_LT);
        r_ex_pred  = 1'b1;
        #1; chk("blt_ovf", w_pc_sel, 1);
        chk("blt_pred_ok", w_mispred, 0);
        set_ex(1'b1, 1'b1, 32'h600, mk_br(c_F_NE), 32'd7, 32'd7, 1'b1);
        #1; chk("bne_equal", w_pc_sel, 0);
        chk("bne_mispred", w_mispred, 1);
        set_ex(1'b1, 1'b1, 32'h600, mk_br(c_F_010), 32'd7, 32'd7, 1'b0);
        #1; chk("f3_010", w_pc_sel, 0);
        tick();
        chk("stall_bcnt", w_bcnt, 1);
        chk("stall_mcnt", w_mcnt, 1);

        // ---------------- saturation at 3, then decay -----------------------
        r_if_pc = 32'h204;
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 1'b0, 32'h204, mk_br(c_F_EQ), 32'd9, 32'd9, 1'b1);
            tick();
        end
        chk("sat_pred", w_pred, 1);
        chk("sat_bcnt", w_bcnt, 6);
        chk("sat_mcnt", w_mcnt, 1);
        set_ex(1'b1, 1'b0, 32'h204, mk_br(c_F_NE), 32'd9, 32'd9, 1'b1);
        tick();
        chk("decay1_pred", w_pred, 1);
        chk("decay1_mcnt", w_mcnt, 2);
        tick();
        chk("decay2_pred", w_pred, 0);
        chk("decay2_bcnt", w_bcnt, 8);
        chk("decay2_mcnt", w_mcnt, 3);

        // ---------------- stall blocks updates ------------------------------
        r_if_pc = 32'h308;
        set_ex(1'b1, 1'b1, 32'h308, mk_br(c_F_NE), 32'd1, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_bcnt", i), w_bcnt, 8);
            chk($sformatf("stall%0d_pred", i), w_pred, 0);
        end
        r_ex_stall = 1'b0;
        tick();
        r_ex_valid = 1'b0;
        #1;
        chk("unstall_bcnt", w_bcnt, 9);
        chk("unstall_mcnt", w_mcnt, 4);
        chk("unstall_pred", w_pred, 1);
        tick();
        chk("unstall_once", w_bcnt, 9);

        // ---------------- jumps and non-control -----------------------------
        r_if_pc = 32'h40C;
        set_ex(1'b1, 1'b0, 32'h40C, c_JAL, 32'd0, 32'd0, 1'b0);
        #1;
        chk("jal_pc_sel", w_pc_sel, 1);
        chk("jal_mispred", w_mispred, 1);
        tick();
        set_ex(1'b1, 1'b0, 32'h40C, c_JALR, 32'd0, 32'd0, 1'b1);
        #1;
        chk("jalr_pc_sel", w_pc_sel, 1);
        chk("jalr_mispred", w_mispred, 0);
        tick();
        chk("jump_pred", w_pred, 0);
        chk("jump_bcnt", w_bcnt, 11);
        chk("jump_mcnt", w_mcnt, 5);
        set_ex(1'b1, 1'b0, 32'h40C, c_ADD, 32'd5, 32'd5, 1'b1);
        #1;
        chk("add_pc_sel", w_pc_sel, 0);
        chk("add_mispred", w_mispred, 0);
        tick();
        chk("add_bcnt", w_bcnt, 11);
        chk("add_mcnt", w_mcnt, 5);

        // ---------------- reset mid-operation -------------------------------
        r_if_pc = 32'h510;
        set_ex(1'b1, 1'b0, 32'h510, mk_br(c_F_EQ), 32'd3, 32'd3, 1'b0);
        #2;
        r_rst = 1'b1;
        #1;
        chk("async_rst_bcnt", w_bcnt, 0);
        chk("async_rst_mcnt", w_mcnt, 0);
        tick();
        r_ex_valid = 1'b0;
        r_rst      = 1'b0;
        #1;
        chk("midrst_pred_510", w_pred, 0);
        chk("midrst_bcnt", w_bcnt, 0);
        r_if_pc = 32'h100;
        #1;
        chk("midrst_pred_100", w_pred, 0);

        // ---------------- static predictor and 4-bit saturation -------------
        for (int i = 0; i < 10; i++) begin
            set_ex(1'b1, 1'b0, 32'h100, mk_br(c_F_EQ), 32'd1, 32'd1, 1'b0);
            tick();
            chk($sformatf("static_pred_%0d", i), w_alt_pred, 0);
        end
        chk("static_mcnt10", w_alt_mcnt, 10);
        chk("static_bcnt10", w_alt_bcnt, 10);
        chk("bimodal_pred", w_pred, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        r_ex_valid = 1'b0;
        #1;
        chk("alt_bcnt_sat", w_alt_bcnt, 15);
        chk("alt_mcnt_sat", w_alt_mcnt, 15);
        chk("main_bcnt20", w_bcnt, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
